// File: rtl/arc4_pkg.sv
// Shared ARC4 key-search types and constants: plaintext-checker FSM states,
// the length-byte address and the printable character range.
package arc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_ISSUE,
    ST_LEN_WAIT,
    ST_BYTE_ISSUE,
    ST_BYTE_CHECK,
    ST_FINISH
  } pt_check_state_t;

  localparam logic [7:0] PT_LEN_ADDR = 8'd0;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

endpackage

// File: rtl/pt_check.sv
// Scans a length-prefixed plaintext for printable chars; done after 3+2L cycles (3+2k on abort at byte k).
// Backpressure: en is taken only while rdy=1; requests during a scan are dropped, not queued.
module pt_check
  import arc4_pkg::*;
#(
  parameter logic [7:0] LO_CHAR = PRINT_LO,
  parameter logic [7:0] HI_CHAR = PRINT_HI
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       done,
  output logic       valid,
  output logic [7:0] bad_idx
);

  pt_check_state_t state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [7:0] bad_idx_q, bad_idx_d;
  logic       char_ok;

  assign char_ok = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    bad_idx_d = bad_idx_q;
    pt_addr   = PT_LEN_ADDR;
    rdy       = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          valid_d   = 1'b0;
          bad_idx_d = 8'd0;
          state_d   = ST_LEN_ISSUE;
        end
      end
      ST_LEN_ISSUE: state_d = ST_LEN_WAIT;
      ST_LEN_WAIT: begin
        len_d = pt_rddata;
        if (pt_rddata == 8'd0) begin
          valid_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          idx_d   = 8'd1;
          state_d = ST_BYTE_ISSUE;
        end
      end
      ST_BYTE_ISSUE: begin
        pt_addr = idx_q;
        state_d = ST_BYTE_CHECK;
      end
      ST_BYTE_CHECK: begin
        // Hold the address so the read port never sees idx+1 on an abort.
        pt_addr = idx_q;
        if (!char_ok) begin
          valid_d   = 1'b0;
          bad_idx_d = idx_q;
          state_d   = ST_FINISH;
        end else if (idx_q == len_q) begin
          valid_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = ST_BYTE_ISSUE;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      valid_q   <= 1'b0;
      bad_idx_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      bad_idx_q <= bad_idx_d;
    end
  end

  assign valid   = valid_q;
  assign bad_idx = bad_idx_q;

endmodule

// File: tb/tb_pt_check.sv
// Bench for pt_check: synchronous-read plaintext memory model plus a reference
// scanner that derives result and latency directly from the memory contents.
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic       done;
  logic       valid;
  logic [7:0] bad_idx;

  logic [7:0] mem [0:255];
  logic [7:0] addr_seq [$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pt_rddata <= mem[pt_addr];

  pt_check dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .pt_addr  (pt_addr),
    .pt_rddata(pt_rddata),
    .done     (done),
    .valid    (valid),
    .bad_idx  (bad_idx)
  );

  // Reference: first non-printable byte in 1..L decides the result and latency.
  function automatic void ref_scan(output logic v, output logic [7:0] bi, output int lat);
    int len;
    len = int'(mem[0]);
    v   = 1'b1;
    bi  = 8'd0;
    lat = 3 + 2 * len;
    for (int k = 1; k <= len; k++) begin
      if (mem[k] < 8'h20 || mem[k] > 8'h7E) begin
        v   = 1'b0;
        bi  = k[7:0];
        lat = 3 + 2 * k;
        break;
      end
    end
  endfunction

  // Starts one scan from idle and waits (bounded) for done.
  task automatic run_scan(output int lat, output logic v, output logic [7:0] bi,
                          output int max_addr, output logic done_after);
    addr_seq.delete();
    max_addr = 0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 2000) begin
      if (addr_seq.size() == 0 || addr_seq[$] != pt_addr) addr_seq.push_back(pt_addr);
      if (int'(pt_addr) > max_addr) max_addr = int'(pt_addr);
      @(negedge clk);
      lat++;
    end
    v  = valid;
    bi = bad_idx;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    int dones;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rdy, done, valid, bad_idx, pt_addr} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0})
      $display("FAIL reset_state: rdy/done/valid/bad_idx/pt_addr got %b/%b/%b/%0d/%0d expected 1/0/0/0/0",
               rdy, done, valid, bad_idx, pt_addr);
    else n_pass++;

    // en together with reset: start must be dropped.
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0 || rdy !== 1'b1)
      $display("FAIL reset_with_en: done pulses %0d rdy %b expected 0 pulses rdy 1", dones, rdy);
    else n_pass++;

    // Reset while in BYTE_CHECK (cycle 4 after accept).
    mem[0] = 8'd3; mem[1] = 8'h61; mem[2] = 8'h62; mem[3] = 8'h63;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pt_addr !== 8'd1 || rdy !== 1'b0)
      $display("FAIL reset_midscan_pre: pt_addr %0d rdy %b expected 1 0", pt_addr, rdy);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({rdy, done, valid, bad_idx, pt_addr} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0})
      $display("FAIL reset_midscan: rdy/done/valid/bad_idx/pt_addr got %b/%b/%b/%0d/%0d expected 1/0/0/0/0",
               rdy, done, valid, bad_idx, pt_addr);
    else n_pass++;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL reset_no_done: got %0d done pulses expected 0", dones);
    else n_pass++;
  endtask

  task automatic test_all_printable();
    int lat, elat, maxa;
    logic v, ev, da;
    logic [7:0] bi, ebi;
    logic [31:0] seq;
    mem[0] = 8'd3; mem[1] = 8'h61; mem[2] = 8'h62; mem[3] = 8'h63;
    ref_scan(ev, ebi, elat);
    run_scan(lat, v, bi, maxa, da);
    n_checks++;
    if (lat !== elat || v !== ev || bi !== ebi)
      $display("FAIL all_printable: lat/valid/bad_idx got %0d/%b/%0d expected %0d/%b/%0d",
               lat, v, bi, elat, ev, ebi);
    else n_pass++;
    seq = 32'd0;
    foreach (addr_seq[i]) seq = {seq[23:0], addr_seq[i]};
    n_checks++;
    if (addr_seq.size() !== 4 || seq !== 32'h00010203)
      $display("FAIL addr_sequence: got %0d entries %h expected 4 entries 00010203", addr_seq.size(), seq);
    else n_pass++;
    n_checks++;
    if (da !== 1'b0 || rdy !== 1'b1 || valid !== 1'b1)
      $display("FAIL done_one_cycle: done %b rdy %b valid %b after finish expected 0 1 1", da, rdy, valid);
    else n_pass++;
  endtask

  task automatic test_early_abort();
    int lat, elat, maxa;
    logic v, ev, da;
    logic [7:0] bi, ebi;
    mem[0] = 8'd5; mem[1] = 8'h48; mem[2] = 8'h07; mem[3] = 8'h78; mem[4] = 8'h79; mem[5] = 8'h7A;
    ref_scan(ev, ebi, elat);
    run_scan(lat, v, bi, maxa, da);
    n_checks++;
    if (lat !== elat || v !== ev || bi !== ebi)
      $display("FAIL early_abort: lat/valid/bad_idx got %0d/%b/%0d expected %0d/%b/%0d",
               lat, v, bi, elat, ev, ebi);
    else n_pass++;
    n_checks++;
    if (maxa !== int'(ebi)) $display("FAIL abort_max_addr: got %0d expected %0d", maxa, ebi);
    else n_pass++;
    n_checks++;
    if (bad_idx !== ebi || valid !== 1'b0)
      $display("FAIL abort_hold: bad_idx %0d valid %b expected %0d 0", bad_idx, valid, ebi);
    else n_pass++;
  endtask

  task automatic test_idle_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bad_idx !== 8'd0 || valid !== 1'b0 || rdy !== 1'b1)
      $display("FAIL idle_reset: bad_idx %0d valid %b rdy %b expected 0 0 1", bad_idx, valid, rdy);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    int lat, elat, maxa;
    logic v, ev, da;
    logic [7:0] bi, ebi;
    mem[0] = 8'd4; mem[1] = 8'h20; mem[2] = 8'h7E; mem[3] = 8'h1F; mem[4] = 8'h41;
    ref_scan(ev, ebi, elat);
    run_scan(lat, v, bi, maxa, da);
    n_checks++;
    if (lat !== elat || v !== ev || bi !== ebi)
      $display("FAIL boundary_lo: lat/valid/bad_idx got %0d/%b/%0d expected %0d/%b/%0d",
               lat, v, bi, elat, ev, ebi);
    else n_pass++;
    mem[1] = 8'h7F;
    ref_scan(ev, ebi, elat);
    run_scan(lat, v, bi, maxa, da);
    n_checks++;
    if (lat !== elat || v !== ev || bi !== ebi)
      $display("FAIL boundary_hi: lat/valid/bad_idx got %0d/%b/%0d expected %0d/%b/%0d",
               lat, v, bi, elat, ev, ebi);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    int lat, elat, maxa;
    logic v, ev, da;
    logic [7:0] bi, ebi;
    mem[0] = 8'd0;
    ref_scan(ev, ebi, elat);
    run_scan(lat, v, bi, maxa, da);
    n_checks++;
    if (lat !== elat || v !== ev || bi !== ebi)
      $display("FAIL len_zero: lat/valid/bad_idx got %0d/%b/%0d expected %0d/%b/%0d",
               lat, v, bi, elat, ev, ebi);
    else n_pass++;
  endtask

  // en held high across three zero-length scans; each scan is lat cycles plus one idle cycle.
  task automatic test_back_to_back();
    int elat, p;
    logic ev;
    logic [7:0] ebi;
    logic [11:0] done_v, rdy_v, valid_v, edone, erdy, evalid;
    mem[0] = 8'd0;
    ref_scan(ev, ebi, elat);
    p = elat + 1;
    done_v = '0; rdy_v = '0; valid_v = '0; edone = '0; erdy = '0; evalid = '0;
    @(negedge clk);
    en = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      done_v[c]  = done;
      rdy_v[c]   = rdy;
      valid_v[c] = valid;
      edone[c]   = (c % p == elat);
      erdy[c]    = (c % p == 0);
      evalid[c]  = (c % p == elat) || (c % p == 0);
    end
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done_v !== edone) $display("FAIL b2b_done: got %b expected %b", done_v, edone);
    else n_pass++;
    n_checks++;
    if (rdy_v !== erdy) $display("FAIL b2b_rdy: got %b expected %b", rdy_v, erdy);
    else n_pass++;
    n_checks++;
    if (valid_v !== evalid) $display("FAIL b2b_valid_hold: got %b expected %b", valid_v, evalid);
    else n_pass++;
    n_checks++;
    if (rdy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_idle: rdy %b done %b expected 1 0", rdy, done);
    else n_pass++;
  endtask

  task automatic test_max_len();
    int lat, elat, maxa;
    logic v, ev, da;
    logic [7:0] bi, ebi;
    mem[0] = 8'd255;
    for (int k = 1; k < 256; k++) mem[k] = 8'h41;
    ref_scan(ev, ebi, elat);
    run_scan(lat, v, bi, maxa, da);
    n_checks++;
    if (lat !== elat || v !== ev || bi !== ebi)
      $display("FAIL max_len: lat/valid/bad_idx got %0d/%b/%0d expected %0d/%b/%0d",
               lat, v, bi, elat, ev, ebi);
    else n_pass++;
    n_checks++;
    if (maxa !== 255 || da !== 1'b0)
      $display("FAIL max_len_addr: max addr %0d done_after %b expected 255 0", maxa, da);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, elat, maxa, len;
    logic v, ev, da;
    logic [7:0] bi, ebi;
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(0, 20);
      mem[0] = len[7:0];
      for (int k = 1; k <= 21; k++)
        mem[k] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(32, 126));
      ref_scan(ev, ebi, elat);
      run_scan(lat, v, bi, maxa, da);
      n_checks++;
      if (lat !== elat || v !== ev || bi !== ebi || da !== 1'b0)
        $display("FAIL random_%0d: lat/valid/bad_idx/done_after got %0d/%b/%0d/%b expected %0d/%b/%0d/0",
                 t, lat, v, bi, da, elat, ev, ebi);
      else n_pass++;
      n_checks++;
      if (maxa !== (ev ? len : int'(ebi)))
        $display("FAIL random_addr_%0d: max addr %0d expected %0d", t, maxa, ev ? len : int'(ebi));
      else n_pass++;
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    rst_n = 1'b0;
    en    = 1'b0;
    test_reset();
    test_all_printable();
    test_early_abort();
    test_idle_reset();
    test_boundaries();
    test_len_zero();
    test_back_to_back();
    test_max_len();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
